// File: rtl/wb2axi_bridge.sv
// Wishbone-classic slave to single-beat AXI4 master bridge with byte-lane steering.
// Optional error reporting on wb_err is enabled by defining WB2AXI_ERR_EN.
module wb2axi_bridge #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int ID_WIDTH   = 4,
  parameter int AXI_ID     = 0,
  parameter int READ_ONLY  = 0
) (
  input  logic                    ACLK,
  input  logic                    ARESET,
  input  logic [ADDR_WIDTH-1:0]   wb_adr,
  input  logic [31:0]             wb_dat,
  input  logic [3:0]              wb_sel,
  input  logic                    wb_we,
  input  logic                    wb_cyc,
  output logic [31:0]             wb_rdt,
  output logic                    wb_ack,
  output logic                    wb_err,
  output logic [ID_WIDTH-1:0]     M_AXI_awid,
  output logic [ADDR_WIDTH-1:0]   M_AXI_awaddr,
  output logic [7:0]              M_AXI_awlen,
  output logic [2:0]              M_AXI_awsize,
  output logic [1:0]              M_AXI_awburst,
  output logic                    M_AXI_awlock,
  output logic [3:0]              M_AXI_awcache,
  output logic [2:0]              M_AXI_awprot,
  output logic [3:0]              M_AXI_awqos,
  output logic [3:0]              M_AXI_awregion,
  output logic                    M_AXI_awvalid,
  input  logic                    M_AXI_awready,
  output logic [DATA_WIDTH-1:0]   M_AXI_wdata,
  output logic [DATA_WIDTH/8-1:0] M_AXI_wstrb,
  output logic                    M_AXI_wlast,
  output logic                    M_AXI_wvalid,
  input  logic                    M_AXI_wready,
  input  logic [ID_WIDTH-1:0]     M_AXI_bid,
  input  logic [1:0]              M_AXI_bresp,
  input  logic                    M_AXI_bvalid,
  output logic                    M_AXI_bready,
  output logic [ID_WIDTH-1:0]     M_AXI_arid,
  output logic [ADDR_WIDTH-1:0]   M_AXI_araddr,
  output logic [7:0]              M_AXI_arlen,
  output logic [2:0]              M_AXI_arsize,
  output logic [1:0]              M_AXI_arburst,
  output logic                    M_AXI_arlock,
  output logic [3:0]              M_AXI_arcache,
  output logic [2:0]              M_AXI_arprot,
  output logic [3:0]              M_AXI_arqos,
  output logic [3:0]              M_AXI_arregion,
  output logic                    M_AXI_arvalid,
  input  logic                    M_AXI_arready,
  input  logic [ID_WIDTH-1:0]     M_AXI_rid,
  input  logic [DATA_WIDTH-1:0]   M_AXI_rdata,
  input  logic [1:0]              M_AXI_rresp,
  input  logic                    M_AXI_rlast,
  input  logic                    M_AXI_rvalid,
  output logic                    M_AXI_rready
);

  localparam int LANES = DATA_WIDTH / 32;
  localparam int LW    = (LANES > 1) ? $clog2(LANES) : 1;
  localparam int SW    = DATA_WIDTH / 8;
`ifdef WB2AXI_ERR_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  typedef enum logic [2:0] {IDLE, RD_ADDR, RD_DATA, WR_REQ, WR_RESP, DONE} state_t;

  state_t                state, state_nxt;
  logic [ADDR_WIDTH-1:0] adr_q, adr_nxt;
  logic [31:0]           dat_q, dat_nxt;
  logic [3:0]            sel_q, sel_nxt;
  logic [31:0]           rdt_q, rdt_nxt;
  logic                  arvalid_q, arvalid_nxt, rready_q, rready_nxt;
  logic                  awvalid_q, awvalid_nxt, wvalid_q, wvalid_nxt, bready_q, bready_nxt;
  logic                  aw_done_q, aw_done_nxt, w_done_q, w_done_nxt;
  logic                  ack_q, ack_nxt, err_q, err_nxt;
  logic                  aw_ok, w_ok, fail;
  logic [LW-1:0]         lane;
  logic [31:0]           rd_lane;

  assign lane    = (LANES > 1) ? adr_q[LW+1:2] : '0;
  assign rd_lane = M_AXI_rdata[lane*32 +: 32];

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      state     <= IDLE;
      adr_q     <= '0;
      dat_q     <= '0;
      sel_q     <= '0;
      rdt_q     <= '0;
      arvalid_q <= 1'b0;
      rready_q  <= 1'b0;
      awvalid_q <= 1'b0;
      wvalid_q  <= 1'b0;
      bready_q  <= 1'b0;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
      ack_q     <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state     <= state_nxt;
      adr_q     <= adr_nxt;
      dat_q     <= dat_nxt;
      sel_q     <= sel_nxt;
      rdt_q     <= rdt_nxt;
      arvalid_q <= arvalid_nxt;
      rready_q  <= rready_nxt;
      awvalid_q <= awvalid_nxt;
      wvalid_q  <= wvalid_nxt;
      bready_q  <= bready_nxt;
      aw_done_q <= aw_done_nxt;
      w_done_q  <= w_done_nxt;
      ack_q     <= ack_nxt;
      err_q     <= err_nxt;
    end
  end

  // AW and W complete independently; a channel counts as done on the edge its handshake occurs.
  assign aw_ok = aw_done_q | (awvalid_q & M_AXI_awready);
  assign w_ok  = w_done_q  | (wvalid_q  & M_AXI_wready);

  always_comb begin
    state_nxt   = state;
    adr_nxt     = adr_q;
    dat_nxt     = dat_q;
    sel_nxt     = sel_q;
    rdt_nxt     = rdt_q;
    arvalid_nxt = arvalid_q;
    rready_nxt  = rready_q;
    awvalid_nxt = awvalid_q;
    wvalid_nxt  = wvalid_q;
    bready_nxt  = bready_q;
    aw_done_nxt = aw_done_q;
    w_done_nxt  = w_done_q;
    ack_nxt     = 1'b0;
    err_nxt     = 1'b0;
    fail        = 1'b0;
    case (state)
      IDLE: begin
        if (wb_cyc) begin
          adr_nxt = wb_adr;
          dat_nxt = wb_dat;
          sel_nxt = wb_sel;
          if (!wb_we) begin
            arvalid_nxt = 1'b1;
            state_nxt   = RD_ADDR;
          end else if (READ_ONLY != 0) begin
            ack_nxt   = !ERR_EN;
            err_nxt   = ERR_EN;
            state_nxt = DONE;
          end else begin
            awvalid_nxt = 1'b1;
            wvalid_nxt  = 1'b1;
            aw_done_nxt = 1'b0;
            w_done_nxt  = 1'b0;
            state_nxt   = WR_REQ;
          end
        end
      end
      RD_ADDR: begin
        if (M_AXI_arready) begin
          arvalid_nxt = 1'b0;
          rready_nxt  = 1'b1;
          state_nxt   = RD_DATA;
        end
      end
      RD_DATA: begin
        if (M_AXI_rvalid) begin
          fail       = M_AXI_rresp[1];
          rready_nxt = 1'b0;
          rdt_nxt    = rd_lane;
          ack_nxt    = !(ERR_EN && fail);
          err_nxt    = ERR_EN && fail;
          state_nxt  = DONE;
        end
      end
      WR_REQ: begin
        if (awvalid_q && M_AXI_awready) begin
          awvalid_nxt = 1'b0;
          aw_done_nxt = 1'b1;
        end
        if (wvalid_q && M_AXI_wready) begin
          wvalid_nxt = 1'b0;
          w_done_nxt = 1'b1;
        end
        if (aw_ok && w_ok) begin
          bready_nxt = 1'b1;
          state_nxt  = WR_RESP;
        end
      end
      WR_RESP: begin
        if (M_AXI_bvalid) begin
          fail       = M_AXI_bresp[1];
          bready_nxt = 1'b0;
          ack_nxt    = !(ERR_EN && fail);
          err_nxt    = ERR_EN && fail;
          state_nxt  = DONE;
        end
      end
      // The master still holds cyc while it sees the ack, so this cycle must not start a new access.
      DONE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign wb_rdt = rdt_q;
  assign wb_ack = ack_q;
  assign wb_err = err_q;

  assign M_AXI_awid     = ID_WIDTH'(AXI_ID);
  assign M_AXI_awaddr   = {adr_q[ADDR_WIDTH-1:2], 2'b00};
  assign M_AXI_awlen    = 8'd0;
  assign M_AXI_awsize   = 3'b010;
  assign M_AXI_awburst  = 2'b01;
  assign M_AXI_awlock   = 1'b0;
  assign M_AXI_awcache  = 4'd0;
  assign M_AXI_awprot   = 3'b000;
  assign M_AXI_awqos    = 4'd0;
  assign M_AXI_awregion = 4'd0;
  assign M_AXI_awvalid  = awvalid_q;
  assign M_AXI_wdata    = {LANES{dat_q}};
  assign M_AXI_wstrb    = SW'(sel_q) << (4 * lane);
  assign M_AXI_wlast    = 1'b1;
  assign M_AXI_wvalid   = wvalid_q;
  assign M_AXI_bready   = bready_q;

  assign M_AXI_arid     = ID_WIDTH'(AXI_ID);
  assign M_AXI_araddr   = {adr_q[ADDR_WIDTH-1:2], 2'b00};
  assign M_AXI_arlen    = 8'd0;
  assign M_AXI_arsize   = 3'b010;
  assign M_AXI_arburst  = 2'b01;
  assign M_AXI_arlock   = 1'b0;
  assign M_AXI_arcache  = 4'd0;
  assign M_AXI_arprot   = 3'b000;
  assign M_AXI_arqos    = 4'd0;
  assign M_AXI_arregion = 4'd0;
  assign M_AXI_arvalid  = arvalid_q;
  assign M_AXI_rready   = rready_q;

  wire unused_ok = ^{adr_q[1:0], M_AXI_rresp[0], M_AXI_bresp[0], M_AXI_rid, M_AXI_bid, M_AXI_rlast};

endmodule

// File: tb/tb_wb2axi_bridge.sv
// Scoreboard bench for wb2axi_bridge (64-bit AXI, read-write) with a delay-programmable AXI slave.
module tb_wb2axi_bridge;
  localparam int AW = 32;
  localparam int DW = 64;
  localparam int IW = 4;
`ifdef WB2AXI_ERR_EN
  localparam bit ERR_BUILD = 1'b1;
`else
  localparam bit ERR_BUILD = 1'b0;
`endif

  logic ACLK = 1'b0, ARESET = 1'b1;
  logic [AW-1:0] wb_adr = '0;
  logic [31:0] wb_dat = '0, wb_rdt;
  logic [3:0] wb_sel = '0;
  logic wb_we = 1'b0, wb_cyc = 1'b0, wb_ack, wb_err;
  logic [IW-1:0] awid, arid, bid = '0, rid = '0;
  logic [AW-1:0] awaddr, araddr;
  logic [7:0] awlen, arlen, wstrb;
  logic [2:0] awsize, arsize, awprot, arprot;
  logic [1:0] awburst, arburst, bresp = 2'b00, rresp = 2'b00;
  logic awlock, arlock, wlast, rlast = 1'b1;
  logic [3:0] awcache, arcache, awqos, arqos, awregion, arregion;
  logic awvalid, awready = 1'b0, wvalid, wready = 1'b0, bvalid = 1'b0, bready;
  logic arvalid, arready = 1'b0, rvalid = 1'b0, rready;
  logic [DW-1:0] wdata, rdata = '0;

  wb2axi_bridge #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .ID_WIDTH(IW), .AXI_ID(5), .READ_ONLY(0)) dut (
    .ACLK(ACLK), .ARESET(ARESET),
    .wb_adr(wb_adr), .wb_dat(wb_dat), .wb_sel(wb_sel), .wb_we(wb_we), .wb_cyc(wb_cyc),
    .wb_rdt(wb_rdt), .wb_ack(wb_ack), .wb_err(wb_err),
    .M_AXI_awid(awid), .M_AXI_awaddr(awaddr), .M_AXI_awlen(awlen), .M_AXI_awsize(awsize),
    .M_AXI_awburst(awburst), .M_AXI_awlock(awlock), .M_AXI_awcache(awcache), .M_AXI_awprot(awprot),
    .M_AXI_awqos(awqos), .M_AXI_awregion(awregion), .M_AXI_awvalid(awvalid), .M_AXI_awready(awready),
    .M_AXI_wdata(wdata), .M_AXI_wstrb(wstrb), .M_AXI_wlast(wlast), .M_AXI_wvalid(wvalid),
    .M_AXI_wready(wready),
    .M_AXI_bid(bid), .M_AXI_bresp(bresp), .M_AXI_bvalid(bvalid), .M_AXI_bready(bready),
    .M_AXI_arid(arid), .M_AXI_araddr(araddr), .M_AXI_arlen(arlen), .M_AXI_arsize(arsize),
    .M_AXI_arburst(arburst), .M_AXI_arlock(arlock), .M_AXI_arcache(arcache), .M_AXI_arprot(arprot),
    .M_AXI_arqos(arqos), .M_AXI_arregion(arregion), .M_AXI_arvalid(arvalid), .M_AXI_arready(arready),
    .M_AXI_rid(rid), .M_AXI_rdata(rdata), .M_AXI_rresp(rresp), .M_AXI_rlast(rlast),
    .M_AXI_rvalid(rvalid), .M_AXI_rready(rready)
  );

  typedef struct {logic [31:0] addr; int hold;} a_exp_t;
  typedef struct {logic [63:0] data; logic [7:0] strb; int hold;} w_exp_t;
  typedef struct {logic err; logic [31:0] rdt; int lat;} c_exp_t;

  a_exp_t ar_q[$], aw_q[$];
  w_exp_t w_q[$];
  c_exp_t c_q[$];

  int total = 0, bad = 0;
  int cycle_cnt = 0, start_cycle = 0, done_cnt = 0;
  int ar_delay = 0, aw_delay = 0, w_delay = 0, r_delay = 0, b_delay = 0;
  logic [63:0] r_data = '0;
  logic [1:0] r_resp = 2'b00, b_resp = 2'b00;

  initial forever #5 ACLK = ~ACLK;
  initial forever begin
    @(posedge ACLK);
    cycle_cnt++;
  end

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // AXI slave: READY/VALID raised after a programmable number of cycles, updated just after each edge.
  initial begin
    int ar_cnt = 0, aw_cnt = 0, w_cnt = 0, r_cnt = 0, b_cnt = 0;
    logic r_hs, b_hs;
    forever begin
      @(negedge ACLK);
      r_hs = rvalid && rready;
      b_hs = bvalid && bready;
      @(posedge ACLK);
      #1;
      if (ARESET) begin
        arready = 0; awready = 0; wready = 0; rvalid = 0; bvalid = 0;
        ar_cnt = 0; aw_cnt = 0; w_cnt = 0; r_cnt = 0; b_cnt = 0;
      end else begin
        if (arvalid) begin arready = (ar_cnt >= ar_delay); ar_cnt++; end
        else begin arready = 0; ar_cnt = 0; end
        if (awvalid) begin awready = (aw_cnt >= aw_delay); aw_cnt++; end
        else begin awready = 0; aw_cnt = 0; end
        if (wvalid) begin wready = (w_cnt >= w_delay); w_cnt++; end
        else begin wready = 0; w_cnt = 0; end
        if (r_hs) begin rvalid = 0; r_cnt = 0; end
        else if (rready && !rvalid) begin
          if (r_cnt >= r_delay) begin rvalid = 1; rdata = r_data; rresp = r_resp; end
          else r_cnt++;
        end
        if (b_hs) begin bvalid = 0; b_cnt = 0; end
        else if (bready && !bvalid) begin
          if (b_cnt >= b_delay) begin bvalid = 1; bresp = b_resp; end
          else b_cnt++;
        end
      end
    end
  end

  // Monitor: pops the scoreboard whenever the DUT presents a handshake or a completion.
  initial begin
    int ar_hold = 0, aw_hold = 0, w_hold = 0;
    logic bready_prev = 1'b0;
    a_exp_t ea;
    w_exp_t ew;
    c_exp_t ec;
    forever begin
      @(negedge ACLK);
      if (ARESET) begin
        ar_hold = 0; aw_hold = 0; w_hold = 0; bready_prev = 1'b0;
      end else begin
        if (arvalid) ar_hold++;
        if (awvalid) aw_hold++;
        if (wvalid) w_hold++;
        if (arvalid && arready) begin
          if (ar_q.size() == 0) begin
            total++; bad++;
            $display("[TB] FAIL ar_unexpected actual=%0h required=none", araddr);
          end else begin
            ea = ar_q.pop_front();
            checkOutput("araddr", 64'(araddr), 64'(ea.addr));
            checkOutput("ar_const", {arid, arlen, arsize, arburst, arlock, arcache, arprot, arqos, arregion},
                        {4'd5, 8'd0, 3'b010, 2'b01, 1'b0, 4'd0, 3'd0, 4'd0, 4'd0});
            if (ea.hold >= 0) checkOutput("arvalid_hold", 64'(ar_hold), 64'(ea.hold));
          end
          ar_hold = 0;
        end
        if (awvalid && awready) begin
          if (aw_q.size() == 0) begin
            total++; bad++;
            $display("[TB] FAIL aw_unexpected actual=%0h required=none", awaddr);
          end else begin
            ea = aw_q.pop_front();
            checkOutput("awaddr", 64'(awaddr), 64'(ea.addr));
            checkOutput("aw_const", {awid, awlen, awsize, awburst, awlock, awcache, awprot, awqos, awregion},
                        {4'd5, 8'd0, 3'b010, 2'b01, 1'b0, 4'd0, 3'd0, 4'd0, 4'd0});
            if (ea.hold >= 0) checkOutput("awvalid_hold", 64'(aw_hold), 64'(ea.hold));
          end
          aw_hold = 0;
        end
        if (wvalid && wready) begin
          if (w_q.size() == 0) begin
            total++; bad++;
            $display("[TB] FAIL w_unexpected actual=%0h required=none", wdata);
          end else begin
            ew = w_q.pop_front();
            checkOutput("wdata", wdata, ew.data);
            checkOutput("wstrb_wlast", {wstrb, wlast}, {ew.strb, 1'b1});
            if (ew.hold >= 0) checkOutput("wvalid_hold", 64'(w_hold), 64'(ew.hold));
          end
          w_hold = 0;
        end
        if (bready && !bready_prev) checkOutput("bready_after_aw_w", {awvalid, wvalid}, 2'b00);
        bready_prev = bready;
        if (wb_ack || wb_err) begin
          if (c_q.size() == 0) begin
            total++; bad++;
            $display("[TB] FAIL completion_unexpected actual=%b%b required=none", wb_ack, wb_err);
          end else begin
            ec = c_q.pop_front();
            checkOutput("ack_err", {wb_ack, wb_err}, {!ec.err, ec.err});
            checkOutput("wb_rdt", 64'(wb_rdt), 64'(ec.rdt));
            if (ec.lat >= 0) checkOutput("latency", 64'(cycle_cnt + 1 - start_cycle), 64'(ec.lat));
          end
          done_cnt++;
        end
      end
    end
  end

  // Drives one Wishbone access, holds cyc through the cycle after the ack, then releases it.
  task automatic applyStimulus(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                               input logic [3:0] sel, input logic [31:0] exp_addr,
                               input logic [63:0] exp_wdata, input logic [7:0] exp_strb,
                               input int a_hold, input int w_hold_exp, input logic exp_err,
                               input logic [31:0] exp_rdt, input int exp_lat, input logic scramble);
    int n0;
    bit seen;
    if (we) begin
      aw_q.push_back('{exp_addr, a_hold});
      w_q.push_back('{exp_wdata, exp_strb, w_hold_exp});
    end else begin
      ar_q.push_back('{exp_addr, a_hold});
    end
    c_q.push_back('{exp_err, exp_rdt, exp_lat});
    @(posedge ACLK);
    #1;
    wb_adr = adr; wb_dat = dat; wb_sel = sel; wb_we = we; wb_cyc = 1'b1;
    start_cycle = cycle_cnt;
    n0 = done_cnt;
    seen = 0;
    for (int i = 0; i < 200 && !seen; i++) begin
      @(posedge ACLK);
      if (scramble && i == 0) begin
        #1;
        wb_adr = adr ^ 32'h0000_0004;
        wb_dat = ~dat;
      end
      if (done_cnt != n0) seen = 1;
    end
    if (!seen) begin
      total++; bad++;
      $display("[TB] FAIL completion_timeout actual=none required=ack adr=%0h", adr);
    end
    #1;
    wb_cyc = 1'b0; wb_we = 1'b0; wb_adr = '0; wb_dat = '0; wb_sel = '0;
  endtask

  initial begin
    int waited;
    $display("[TB] start, error reporting build=%0d", ERR_BUILD);
    repeat (3) @(posedge ACLK);
    @(negedge ACLK);
    checkOutput("reset_valids", {arvalid, awvalid, wvalid, rready, bready}, 5'b0);
    checkOutput("reset_wb", {wb_ack, wb_err, wb_rdt}, 34'b0);
    @(posedge ACLK);
    #1 ARESET = 1'b0;
    @(negedge ACLK);
    checkOutput("idle_after_reset", {arvalid, awvalid, wvalid, rready, bready, wb_ack, wb_err}, 7'b0);

    r_data = 64'h5555_5555_DEAD_BEEF;
    applyStimulus(0, 32'h100, 32'h0, 4'h0, 32'h100, 64'h0, 8'h0, 1, 0, 0, 32'hDEAD_BEEF, 4, 0);
    applyStimulus(1, 32'h104, 32'h1234_5678, 4'b0011, 32'h104, 64'h1234_5678_1234_5678, 8'h30,
                  1, 1, 0, 32'hDEAD_BEEF, 4, 0);
    r_data = 64'hCAFE_F00D_1122_3344;
    applyStimulus(0, 32'h10E, 32'h0, 4'h0, 32'h10C, 64'h0, 8'h0, 1, 0, 0, 32'hCAFE_F00D, 4, 0);

    aw_delay = 2;
    applyStimulus(1, 32'h200, 32'hA5A5_5A5A, 4'b1111, 32'h200, 64'hA5A5_5A5A_A5A5_5A5A, 8'h0F,
                  3, 1, 0, 32'hCAFE_F00D, 6, 0);
    aw_delay = 0; w_delay = 3;
    applyStimulus(1, 32'h20C, 32'hFF00_0000, 4'b1000, 32'h20C, 64'hFF00_0000_FF00_0000, 8'h80,
                  1, 4, 0, 32'hCAFE_F00D, 7, 0);
    w_delay = 0;

    r_delay = 10; r_data = 64'h9999_9999_0BAD_F00D;
    applyStimulus(0, 32'h300, 32'h0, 4'h0, 32'h300, 64'h0, 8'h0, 1, 0, 0, 32'h0BAD_F00D, 14, 1);
    r_delay = 0;

    b_resp = 2'b10;
    applyStimulus(1, 32'h400, 32'h00AB_0000, 4'b0100, 32'h400, 64'h00AB_0000_00AB_0000, 8'h04,
                  1, 1, ERR_BUILD, 32'h0BAD_F00D, 4, 0);
    b_resp = 2'b00;

    // Reset while waiting in RD_DATA; no completion is expected for the dropped read.
    r_delay = 30;
    ar_q.push_back('{32'h500, -1});
    @(posedge ACLK);
    #1;
    wb_adr = 32'h500; wb_we = 1'b0; wb_cyc = 1'b1;
    waited = 0;
    while (!rready && waited < 20) begin
      @(posedge ACLK);
      #1;
      waited++;
    end
    checkOutput("reached_rd_data", 64'(rready), 64'd1);
    repeat (2) @(posedge ACLK);
    #1;
    ARESET = 1'b1; wb_cyc = 1'b0; wb_adr = '0;
    repeat (2) @(posedge ACLK);
    #1 ARESET = 1'b0;
    r_delay = 0;
    @(negedge ACLK);
    checkOutput("midread_reset_ar_r", {arvalid, rready}, 2'b00);
    checkOutput("midread_reset_wb", {wb_ack, wb_err, wb_rdt}, 34'b0);

    r_data = 64'hFFFF_FFFF_0000_0001;
    applyStimulus(0, 32'h108, 32'h0, 4'h0, 32'h108, 64'h0, 8'h0, 1, 0, 0, 32'h0000_0001, 4, 0);

    repeat (5) @(posedge ACLK);
    @(negedge ACLK);
    checkOutput("queues_drained", 64'(ar_q.size() + aw_q.size() + w_q.size() + c_q.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL global_timeout actual=running required=finished");
    $fatal(1, "[TB] timeout");
  end
endmodule

// File: doc/wb2axi_bridge.md
Name: wb2axi_bridge

Overview:
Unified Wishbone-classic to AXI4 master bridge. It replaces the separate read-only and read-write converters used under the RISC-V core wrappers. One instance serves an instruction port (READ_ONLY=1) or a data port (READ_ONLY=0). It supports AXI data widths wider than the 32-bit Wishbone side through byte-lane steering. Each transaction is a single-beat AXI access, with one transaction outstanding at a time.

Parameters:
ADDR_WIDTH, 32, AXI and Wishbone address width.
DATA_WIDTH, 32, AXI data width; legal values 32, 64, 128.
ID_WIDTH, 4, AXI ID width.
AXI_ID, 0, constant ID driven on ARID/AWID.
READ_ONLY, 0, 1 = write channels tied off and writes rejected.

Ports:
ACLK  in  1  clock.
ARESET  in  1  reset; synchronous, active-high.
wb_adr  in  ADDR_WIDTH  byte address.
wb_dat  in  32  write data.
wb_sel  in  4  byte enables.
wb_we  in  1  write enable.
wb_cyc  in  1  cycle request.
wb_rdt  out  32  read data.
wb_ack  out  1  transaction done, 1-cycle pulse.
wb_err  out  1  error completion, 1-cycle pulse.
M_AXI_aw*, M_AXI_w*, M_AXI_b*, M_AXI_ar*, M_AXI_r*  per AXI4  standard widths: full AXI4 master channels.
- ID fields are ID_WIDTH wide; data is DATA_WIDTH wide; wstrb is DATA_WIDTH/8 wide.
- LOCK, CACHE, PROT, QOS and REGION are present.

Behaviour:
- Reset (ARESET=1 at an ACLK edge):
  - State = IDLE.
  - All VALIDs = 0; RREADY = BREADY = 0.
  - wb_ack = wb_err = 0; wb_rdt = 0.
- Any transaction in flight is dropped; the interconnect is reset together with the bridge.
- Constant outputs:
  - LEN = 0, SIZE = 3'b010, BURST = INCR, WLAST = 1.
  - LOCK = CACHE = QOS = REGION = 0, PROT = 3'b000.
  - ID = AXI_ID.
- Lane steering: L = wb_adr[log2(DATA_WIDTH/8)-1:2] (L = 0 when DATA_WIDTH = 32).
  - WDATA = wb_dat replicated across all lanes.
  - WSTRB = wb_sel shifted left by 4*L.
  - wb_rdt = RDATA lane L.
- AxADDR = {captured wb_adr[ADDR_WIDTH-1:2], 2'b00}.
- FSM states: IDLE, RD_ADDR, RD_DATA, WR_REQ, WR_RESP, DONE.
- IDLE: on wb_cyc=1, capture adr/dat/sel/we and go to the next state the following cycle.
  - wb_we=0: to RD_ADDR, with ARVALID=1.
  - wb_we=1 and READ_ONLY=0: to WR_REQ, with AWVALID=WVALID=1.
  - wb_we=1 and READ_ONLY=1: to DONE with a completion pulse; no AXI traffic.
- RD_ADDR: hold ARVALID until ARREADY. Then ARVALID=0, RREADY=1, go to RD_DATA.
- RD_DATA: on RVALID, capture the lane, drop RREADY, pulse the completion, go to DONE.
- WR_REQ:
  - AW and W handshake independently; each VALID drops after its own READY.
  - Internal done flags track each channel.
  - Move to WR_RESP with BREADY=1 once both have completed, including same-cycle completion.
  - WVALID never waits for AWREADY.
- WR_RESP: on BVALID, drop BREADY, pulse the completion, go to DONE.
- Completion pulse: wb_ack (or wb_err, see the optional feature) is high for exactly one cycle.
- DONE: lasts one cycle and ignores wb_cyc, because the master still holds cyc in the ack cycle. Returns to IDLE.
- Latency with READY/VALID always high:
  - Read: cyc to ack = 4 cycles.
  - Write: cyc to ack = 4 cycles.
- wb_rdt holds its last captured value until the next read completes.
- Wishbone inputs are ignored outside IDLE, so a mid-transaction change of adr or dat has no effect.
- If wb_cyc drops while a transaction is in flight, the AXI transaction still completes and the ack is still issued.

Optional Feature:
WB2AXI_ERR_EN.
- Defined:
  - An RRESP or BRESP of SLVERR/DECERR pulses wb_err instead of wb_ack.
  - A read error still updates wb_rdt.
  - A write attempted with READ_ONLY=1 pulses wb_err.
- Undefined:
  - wb_err is tied to 0.
  - All completions pulse wb_ack and the response codes are ignored.

Test Plan:
- Read, DATA_WIDTH=32, all READYs high, wb_adr=0x100, RDATA=0xDEADBEEF -> ARADDR=0x100, ack exactly 4 cycles after cyc, wb_rdt=0xDEADBEEF.
- Write, DATA_WIDTH=64, wb_adr=0x104, sel=4'b0011, dat=0x12345678 -> AWADDR=0x104, WSTRB=8'h30, WDATA=0x1234567812345678, one ack after BVALID.
- AWREADY delayed 3 cycles, WREADY immediate -> WVALID drops after 1 cycle, AWVALID held for 3, BREADY asserted only after both handshakes, single ack.
- RVALID delayed 10 cycles with wb_adr changed mid-wait -> ARADDR unchanged, ack in the cycle after RVALID, no second AR in the DONE cycle even though cyc is still high.
- With WB2AXI_ERR_EN, BRESP=2'b10 -> wb_err pulses once and wb_ack stays 0; without the macro, wb_ack pulses and wb_err stays 0.
- ARESET asserted in RD_DATA, then released -> ARVALID=RREADY=0 and state IDLE; the next read completes normally with value 0x00000001.
